// File: rtl/gate_test_pkg.sv
// Shared definitions for the gate exerciser: FSM states, vector count and
// the bit positions of each gate input inside the stimulus vector.
package gate_test_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int unsigned NUM_VECTORS = 32;

  localparam int unsigned A = 0;
  localparam int unsigned B = 1;
  localparam int unsigned D = 2;
  localparam int unsigned E = 3;
  localparam int unsigned G = 4;

endpackage

// File: rtl/golden_gate_model.sv
// Reference model of the gate DUT: expected c, f and h for a stimulus vector.
module golden_gate_model
  import gate_test_pkg::*;
(
  input  logic [4:0] vec,
  output logic       exp_c,
  output logic       exp_f,
  output logic       exp_h
);

  always_comb begin
    exp_c = vec[A] & vec[B];
    exp_f = vec[D] | vec[E];
    exp_h = ~vec[G];
  end

endmodule

// File: rtl/gate_exerciser.sv
// Exhaustively drives all 32 input patterns into a small gate DUT, checks
// each response against the golden model and reports pass/fail summary.
module gate_exerciser
  import gate_test_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dut_c,
  input  logic             dut_f,
  input  logic             dut_h,
  output logic [4:0]       stim,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [4:0]       fail_vector
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [4:0] LAST_VEC    = 5'(NUM_VECTORS - 1);

  state_t           state, state_n;
  logic [4:0]       vec, vec_n;
  logic [3:0]       cnt, cnt_n;
  logic [CNT_W-1:0] err_n;
  logic [4:0]       fail_n;
  logic             seen_fail, seen_fail_n;
  logic             busy_n, done_n, pass_n;
  logic             exp_c, exp_f, exp_h;
  logic             mismatch;

  golden_gate_model u_model (
    .vec   (vec),
    .exp_c (exp_c),
    .exp_f (exp_f),
    .exp_h (exp_h)
  );

  assign mismatch = {dut_c, dut_f, dut_h} != {exp_c, exp_f, exp_h};
  assign stim     = vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      vec         <= '0;
      cnt         <= '0;
      err_count   <= '0;
      fail_vector <= '0;
      seen_fail   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else begin
      state       <= state_n;
      vec         <= vec_n;
      cnt         <= cnt_n;
      err_count   <= err_n;
      fail_vector <= fail_n;
      seen_fail   <= seen_fail_n;
      busy        <= busy_n;
      done        <= done_n;
      pass        <= pass_n;
    end
  end

  always_comb begin
    state_n     = state;
    vec_n       = vec;
    cnt_n       = cnt;
    err_n       = err_count;
    fail_n      = fail_vector;
    seen_fail_n = seen_fail;

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n     = SETTLE;
          vec_n       = '0;
          cnt_n       = SETTLE_LOAD;
          err_n       = '0;
          fail_n      = '0;
          seen_fail_n = 1'b0;
        end
      end
      SETTLE: begin
        if (cnt == '0) state_n = CHECK;
        else           cnt_n   = cnt - 4'd1;
      end
      CHECK: begin
        if (mismatch) begin
          err_n = err_count + CNT_W'(1);
          if (!seen_fail) begin
            seen_fail_n = 1'b1;
            fail_n      = vec;
          end
        end
        if (vec == LAST_VEC) begin
          state_n = DONE;
        end else begin
          state_n = SETTLE;
          vec_n   = vec + 5'd1;
          cnt_n   = SETTLE_LOAD;
        end
      end
    endcase

    // Status flags are decoded from next-state values so they come straight off flops.
    busy_n = (state_n == SETTLE) || (state_n == CHECK);
    done_n = (state_n == DONE);
    pass_n = done_n && (err_n == '0);
  end

endmodule
